// File: rtl/hb_cmd_initiator.sv
// hb_cmd_initiator
// Host-side initiator for the 34-bit command/response link into the CPU's bus
// master. It takes one read or write request at a time and sends an
// address command unless the address cache hits. It then sends a write or
// read command and waits for the matching response word. Read data or an
// error is returned to the requester as a single-cycle completion pulse.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   req_valid  in   1   request present (held until req_ready is seen)
//   req_ready  out  1   request accepted this cycle (high only in IDLE)
//   req_we     in   1   1 = write, 0 = read
//   req_addr   in  32   byte address, bits [1:0] ignored
//   req_wdata  in  32   write data
//   resp_valid out  1   one-cycle completion pulse
//   resp_rdata out 32   read data on a successful read, else 0
//   resp_err   out  1   bus error, wrong response type or timeout
//   cmd_stb    out  1   command word valid
//   cmd_word   out 34   command word
//   cmd_busy   in   1   master cannot take a command this cycle
//   rsp_stb    in   1   response word valid (single cycle)
//   rsp_word   in  34   response word

module hb_cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit ADDR_CACHE     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        cmd_stb,
    output logic [33:0] cmd_word,
    input  logic        cmd_busy,
    input  logic        rsp_stb,
    input  logic [33:0] rsp_word
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND_ADDR = 3'd1;
    localparam logic [2:0] S_SEND_DATA = 3'd2;
    localparam logic [2:0] S_WAIT_RSP  = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [1:0] RSP_WACK  = 2'b00;
    localparam logic [1:0] RSP_RDATA = 2'b01;
    localparam logic [1:0] RSP_ECHO  = 2'b10;

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic        lat_we;
    logic [29:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        addr_valid;
    logic [29:0] last_addr;
    logic [9:0]  tmo_cnt;

    logic        cache_hit;
    logic [33:0] req_addr_cmd;
    logic [33:0] req_data_cmd;
    logic [33:0] lat_data_cmd;
    logic [1:0]  rsp_type;
    logic        rsp_terminal;
    logic        rsp_ok;
    logic        tmo_expired;

    // Byte-lane bits of the address never reach the link.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    // Gating with reset keeps req_ready low while reset is held, even though
    // the state register already reads IDLE during that time.
    assign req_ready = (state == S_IDLE) && reset;

    assign cache_hit    = ADDR_CACHE && addr_valid && (req_addr[31:2] == last_addr);
    assign req_addr_cmd = {2'b10, 1'b0, 1'b1, req_addr[31:2]};
    assign req_data_cmd = req_we ? {2'b01, req_wdata} : {2'b00, 32'h0};
    assign lat_data_cmd = lat_we ? {2'b01, lat_wdata} : {2'b00, 32'h0};

    // Address echoes are never terminal. Every other type ends the wait,
    // and a type that does not match the request counts as an error.
    assign rsp_type     = rsp_word[33:32];
    assign rsp_terminal = rsp_stb && (rsp_type != RSP_ECHO);
    assign rsp_ok       = lat_we ? (rsp_type == RSP_WACK) : (rsp_type == RSP_RDATA);
    assign tmo_expired  = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= 30'h0;
            lat_wdata  <= 32'h0;
            addr_valid <= 1'b0;
            last_addr  <= 30'h0;
            tmo_cnt    <= 10'h0;
            cmd_stb    <= 1'b0;
            cmd_word   <= 34'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            // Completion outputs are pulses; they are only set on DONE entry.
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr[31:2];
                        lat_wdata <= req_wdata;
                        cmd_stb   <= 1'b1;
                        if (cache_hit) begin
                            cmd_word <= req_data_cmd;
                            state    <= S_SEND_DATA;
                        end else begin
                            cmd_word <= req_addr_cmd;
                            state    <= S_SEND_ADDR;
                        end
                    end
                end

                S_SEND_ADDR: begin
                    // The data word follows the address with no idle gap.
                    if (!cmd_busy) begin
                        last_addr  <= lat_addr;
                        addr_valid <= 1'b1;
                        cmd_word   <= lat_data_cmd;
                        state      <= S_SEND_DATA;
                    end
                end

                S_SEND_DATA: begin
                    if (!cmd_busy) begin
                        cmd_stb  <= 1'b0;
                        cmd_word <= 34'h0;
                        tmo_cnt  <= 10'h0;
                        state    <= S_WAIT_RSP;
                    end
                end

                S_WAIT_RSP: begin
                    // A terminal response arriving on the expiry cycle wins.
                    if (rsp_terminal) begin
                        resp_valid <= 1'b1;
                        resp_err   <= !rsp_ok;
                        resp_rdata <= (rsp_ok && !lat_we) ? rsp_word[31:0] : 32'h0;
                        state      <= S_DONE;
                    end else if (tmo_expired) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end

                S_DONE: begin
                    // After a failure the master's address register is suspect,
                    // so the next request must resend the address.
                    if (resp_err) begin
                        addr_valid <= 1'b0;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    cmd_stb  <= 1'b0;
                    cmd_word <= 34'h0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hb_cmd_initiator.sv
// Directed testbench for hb_cmd_initiator. Two instances share clock and
// reset: index 0 has the address cache enabled and index 1 has it disabled.
// The bench acts as requester and as bus master for each transaction.

module tb_hb_cmd_initiator;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        cmd_stb    [2];
    logic [33:0] cmd_word   [2];
    logic        cmd_busy   [2];
    logic        rsp_stb    [2];
    logic [33:0] rsp_word   [2];

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    // Per-transaction observations filled by applyStimulus.
    logic [33:0] got_words[$];
    logic [33:0] got_w0, got_w1;
    int          got_nwords, got_lat, got_wait, stall_cnt;
    logic        stall_bad, got_valid, got_err, pulse_ok, ready_after;
    logic [31:0] got_rdata;
    logic        seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hb_cmd_initiator #(.TIMEOUT_CYCLES(TMO), .ADDR_CACHE(1'b1)) dut_cache (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .cmd_stb(cmd_stb[0]), .cmd_word(cmd_word[0]), .cmd_busy(cmd_busy[0]),
        .rsp_stb(rsp_stb[0]), .rsp_word(rsp_word[0])
    );

    hb_cmd_initiator #(.TIMEOUT_CYCLES(TMO), .ADDR_CACHE(1'b0)) dut_nocache (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .cmd_stb(cmd_stb[1]), .cmd_word(cmd_word[1]), .cmd_busy(cmd_busy[1]),
        .rsp_stb(rsp_stb[1]), .rsp_word(rsp_word[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one request through DUT d. n1/n2 are the cycles after the data
    // word transfers at which w1/w2 are presented (0 = not presented).
    task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int busy,
                                 input int n1, input logic [33:0] w1,
                                 input int n2, input logic [33:0] w2);
        logic        ready;
        logic        data_done;
        logic [33:0] stall_word;
        int          rem, t0, ed;
        got_words.delete();
        got_valid = 1'b0; got_err = 1'b0; got_rdata = 32'h0;
        got_lat = -1; got_wait = -1; stall_cnt = 0; stall_bad = 1'b0;
        pulse_ok = 1'b0; ready_after = 1'b0; stall_word = 34'h0;
        got_w0 = '1; got_w1 = '1; got_nwords = 0;

        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
        ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ready = req_ready[d];
            tick();
            if (ready) break;
        end
        req_valid[d] = 1'b0;
        if (!ready) begin
            checkOutput("accept_bound", 64'd0, 64'd1);
            return;
        end
        t0 = cyc;

        rem = busy;
        cmd_busy[d] = (rem > 0);
        data_done = 1'b0;
        for (int i = 0; i < 100 && !data_done; i++) begin
            if (cmd_stb[d] && cmd_busy[d]) begin
                if (stall_cnt == 0) stall_word = cmd_word[d];
                else if (cmd_word[d] !== stall_word) stall_bad = 1'b1;
                stall_cnt++;
            end else if (cmd_stb[d]) begin
                got_words.push_back(cmd_word[d]);
                if (!cmd_word[d][33]) data_done = 1'b1;
            end
            tick();
            if (rem > 0) rem--;
            cmd_busy[d] = (rem > 0);
        end
        got_nwords = got_words.size();
        if (got_nwords > 0) got_w0 = got_words[0];
        if (got_nwords > 1) got_w1 = got_words[1];
        if (!data_done) begin
            checkOutput("data_xfer_bound", 64'd0, 64'd1);
            return;
        end
        ed = cyc;

        for (int k = 1; k <= 100; k++) begin
            rsp_stb[d] = 1'b0; rsp_word[d] = 34'h0;
            if (resp_valid[d]) begin
                got_valid = 1'b1; got_rdata = resp_rdata[d]; got_err = resp_err[d];
                got_lat = cyc + 1 - t0; got_wait = cyc - ed;
                break;
            end
            if (k == n1) begin rsp_stb[d] = 1'b1; rsp_word[d] = w1; end
            else if (k == n2) begin rsp_stb[d] = 1'b1; rsp_word[d] = w2; end
            tick();
        end
        rsp_stb[d] = 1'b0; rsp_word[d] = 34'h0;
        tick();
        pulse_ok = !resp_valid[d];
        ready_after = req_ready[d];
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
            cmd_busy[i] = 1'b0; rsp_stb[i] = 1'b0; rsp_word[i] = 34'h0;
        end
        reset = 1'b0;
        tick(); tick(); tick();
        checkOutput("rst_req_ready", {63'd0, req_ready[0]}, 64'd0);
        checkOutput("rst_cmd_stb", {63'd0, cmd_stb[0]}, 64'd0);
        checkOutput("rst_cmd_word", {30'd0, cmd_word[0]}, 64'd0);
        checkOutput("rst_resp_valid", {63'd0, resp_valid[0]}, 64'd0);
        reset = 1'b1;
        #1;
        checkOutput("rel_req_ready", {63'd0, req_ready[0]}, 64'd1);

        // Write to address 0, ack two cycles after the data word.
        applyStimulus(0, 1'b1, 32'h0000_0000, 32'hAABB_CCDD, 0, 2, 34'h0, 0, 34'h0);
        checkOutput("wr_nwords", got_nwords, 2);
        checkOutput("wr_addr_word", {30'd0, got_w0}, 64'h2_4000_0000);
        checkOutput("wr_data_word", {30'd0, got_w1}, 64'h1_AABB_CCDD);
        checkOutput("wr_valid", {63'd0, got_valid}, 64'd1);
        checkOutput("wr_err", {63'd0, got_err}, 64'd0);
        checkOutput("wr_latency", got_lat, 5);
        checkOutput("wr_one_pulse", {63'd0, pulse_ok}, 64'd1);
        checkOutput("wr_ready_after_done", {63'd0, ready_after}, 64'd1);

        // Read at 0x30, address miss.
        applyStimulus(0, 1'b0, 32'h0000_0030, 32'h0, 0, 1, 34'h1_1234_5678, 0, 34'h0);
        checkOutput("rd_nwords", got_nwords, 2);
        checkOutput("rd_addr_word", {30'd0, got_w0}, 64'h2_4000_000C);
        checkOutput("rd_read_word", {30'd0, got_w1}, 64'h0);
        checkOutput("rd_rdata", got_rdata, 64'h1234_5678);
        checkOutput("rd_latency", got_lat, 4);

        // Same address again: cache hit, one word, one cycle shorter.
        applyStimulus(0, 1'b0, 32'h0000_0031, 32'h0, 0, 1, 34'h1_CAFE_F00D, 0, 34'h0);
        checkOutput("hit_nwords", got_nwords, 1);
        checkOutput("hit_read_word", {30'd0, got_w0}, 64'h0);
        checkOutput("hit_rdata", got_rdata, 64'hCAFE_F00D);
        checkOutput("hit_latency", got_lat, 3);

        // Without the cache the address word is always re-sent.
        applyStimulus(1, 1'b0, 32'h0000_0030, 32'h0, 0, 1, 34'h1_1111_2222, 0, 34'h0);
        applyStimulus(1, 1'b0, 32'h0000_0030, 32'h0, 0, 1, 34'h1_3333_4444, 0, 34'h0);
        checkOutput("nc_nwords", got_nwords, 2);
        checkOutput("nc_addr_word", {30'd0, got_w0}, 64'h2_4000_000C);
        checkOutput("nc_rdata", got_rdata, 64'h3333_4444);
        checkOutput("nc_latency", got_lat, 4);

        // Master busy for four cycles while the address word is offered.
        applyStimulus(0, 1'b1, 32'h0000_0040, 32'h1122_3344, 4, 3, 34'h0, 0, 34'h0);
        checkOutput("stall_cycles", stall_cnt, 4);
        checkOutput("stall_stable", {63'd0, stall_bad}, 64'd0);
        checkOutput("stall_nwords", got_nwords, 2);
        checkOutput("stall_addr_word", {30'd0, got_w0}, 64'h2_4000_0010);
        checkOutput("stall_data_word", {30'd0, got_w1}, 64'h1_1122_3344);
        checkOutput("stall_latency", got_lat, 10);
        checkOutput("stall_err", {63'd0, got_err}, 64'd0);

        // Read with no response at all: timeout.
        applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 34'h0, 0, 34'h0);
        checkOutput("tmo_nwords", got_nwords, 1);
        checkOutput("tmo_valid", {63'd0, got_valid}, 64'd1);
        checkOutput("tmo_err", {63'd0, got_err}, 64'd1);
        checkOutput("tmo_rdata", got_rdata, 64'h0);
        checkOutput("tmo_wait", got_wait, TMO);

        // A late response in IDLE must be ignored.
        rsp_stb[0] = 1'b1; rsp_word[0] = 34'h1_DEAD_BEEF;
        tick();
        rsp_stb[0] = 1'b0; rsp_word[0] = 34'h0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid[0] || cmd_stb[0]) seen = 1'b1;
            tick();
        end
        checkOutput("late_rsp_ignored", {63'd0, seen}, 64'd0);
        checkOutput("late_rsp_ready", {63'd0, req_ready[0]}, 64'd1);

        // The timeout dropped the cached address.
        applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 0, 2, 34'h1_0BAD_F00D, 0, 34'h0);
        checkOutput("post_tmo_nwords", got_nwords, 2);
        checkOutput("post_tmo_addr_word", {30'd0, got_w0}, 64'h2_4000_0010);
        checkOutput("post_tmo_rdata", got_rdata, 64'h0BAD_F00D);

        // Response on the very cycle the counter expires wins.
        applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 0, TMO, 34'h1_5A5A_5A5A, 0, 34'h0);
        checkOutput("edge_err", {63'd0, got_err}, 64'd0);
        checkOutput("edge_rdata", got_rdata, 64'h5A5A_5A5A);
        checkOutput("edge_wait", got_wait, TMO);

        // Address echo is ignored, then a bus error ends the write.
        applyStimulus(0, 1'b1, 32'h0000_0040, 32'h0000_0077, 0, 1, 34'h2_0000_0010, 3, 34'h3_0000_0000);
        checkOutput("echo_nwords", got_nwords, 1);
        checkOutput("echo_err", {63'd0, got_err}, 64'd1);
        checkOutput("echo_wait", got_wait, 3);
        checkOutput("echo_rdata", got_rdata, 64'h0);

        // Write ack arriving for a read is an error.
        applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 0, 1, 34'h0, 0, 34'h0);
        checkOutput("wrongtype_nwords", got_nwords, 2);
        checkOutput("wrongtype_err", {63'd0, got_err}, 64'd1);
        checkOutput("wrongtype_rdata", got_rdata, 64'h0);

        // Prime the cache at 0x80, then reset in the middle of a hit read.
        applyStimulus(0, 1'b0, 32'h0000_0080, 32'h0, 0, 1, 34'h1_0000_0080, 0, 34'h0);
        checkOutput("prime_rdata", got_rdata, 64'h80);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0000_0080;
        tick();
        req_valid[0] = 1'b0;
        checkOutput("mid_hit_stb", {63'd0, cmd_stb[0]}, 64'd1);
        checkOutput("mid_hit_word", {30'd0, cmd_word[0]}, 64'h0);
        tick(); tick();
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h0000_0100;
        tick();
        req_valid[0] = 1'b0;
        checkOutput("busy_req_ignored", {63'd0, cmd_stb[0]}, 64'd0);
        checkOutput("busy_req_ready", {63'd0, req_ready[0]}, 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_ready", {63'd0, req_ready[0]}, 64'd0);
        checkOutput("mid_rst_cmd", {29'd0, cmd_stb[0], cmd_word[0]}, 64'h0);
        checkOutput("mid_rst_resp", {30'd0, resp_valid[0], resp_err[0], resp_rdata[0]}, 64'h0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid[0]) seen = 1'b1;
        end
        checkOutput("mid_rst_no_resp", {63'd0, seen}, 64'd0);
        reset = 1'b1;
        #1;
        checkOutput("mid_rel_ready", {63'd0, req_ready[0]}, 64'd1);

        // Reset cleared the cache: address word is sent again.
        applyStimulus(0, 1'b0, 32'h0000_0080, 32'h0, 0, 1, 34'h1_0000_0081, 0, 34'h0);
        checkOutput("post_rst_nwords", got_nwords, 2);
        checkOutput("post_rst_addr_word", {30'd0, got_w0}, 64'h2_4000_0020);
        checkOutput("post_rst_rdata", got_rdata, 64'h81);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hb_cmd_initiator.md
Name: hb_cmd_initiator

Overview:
Host-side initiator for the 34-bit command/response link that feeds the CPU's bus master (cmd_stb/cmd_word/cmd_busy, rsp_stb/rsp_word).
- Accepts one simple read or write request at a time.
- Encodes it into address and data/read command words, then waits for the matching response word.
- Returns read data or error to the requester.
- Replaces the testbench-driven stimulus, so the CPU side can generate bus traffic itself.

Parameters:
TIMEOUT_CYCLES, 64, cycles WAIT_RSP waits for a terminal response before reporting an error (1..1023).
ADDR_CACHE, 1, 1 = skip the address command when req_addr[31:2] equals the last address sent; 0 = always send it.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address; bits [1:0] ignored
req_wdata  input  32  write data
resp_valid  output  1  one-cycle completion pulse, no backpressure
resp_rdata  output  32  read data, valid with resp_valid on a read
resp_err  output  1  bus error or timeout, valid with resp_valid
cmd_stb  output  1  command word valid
cmd_word  output  34  command word
cmd_busy  input  1  master cannot accept a command this cycle
rsp_stb  input  1  response word valid (single cycle)
rsp_word  input  34  response word

Behaviour:
- Command encoding:
  - Set address: {2'b10, 1'b0 (absolute), 1'b1 (no increment), req_addr[31:2]}.
  - Write: {2'b01, req_wdata}.
  - Read: {2'b00, 32'h0}.
- Response decoding (rsp_word[33:32]):
  - 00 = write ack.
  - 01 = read data in [31:0].
  - 10 = address echo; never terminal, always ignored.
  - 11 = bus error.
- Command handshake:
  - A word transfers in a cycle with cmd_stb=1 and cmd_busy=0.
  - While cmd_stb=1 and cmd_busy=1, cmd_word is held stable.
  - cmd_stb deasserts in the cycle after the transfer unless the next word follows immediately.
- Reset values (async assert, sync deassert): req_ready=0 during reset and 1 in the first cycle after release, resp_valid=0, resp_rdata=0, resp_err=0, cmd_stb=0, cmd_word=0, state=IDLE, addr_valid=0, last_addr=0, timeout counter=0.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata. Go to SEND_DATA if ADDR_CACHE=1, addr_valid=1 and req_addr[31:2]==last_addr; otherwise go to SEND_ADDR.
  - SEND_ADDR: drive the address word. On transfer, set last_addr and addr_valid=1, then go to SEND_DATA.
  - SEND_DATA: drive the write word (we=1) or the read word (we=0). On transfer, clear the timeout counter and go to WAIT_RSP.
  - WAIT_RSP: the counter increments each cycle.
    - Terminal rsp_stb (00 on a write, 01 on a read, 11 on either) → DONE.
    - Counter reaches TIMEOUT_CYCLES-1 with no terminal response → DONE with err=1.
    - A wrong terminal type (00 during a read, 01 during a write) is treated as an error.
  - DONE: resp_valid=1 for exactly one cycle, then go to IDLE.
    - resp_rdata = rsp_word[31:0] on a successful read, otherwise 0.
    - On error or timeout, clear addr_valid.
- Latency, with cmd_busy=0 and the response arriving N cycles after the data word transfers: resp_valid occurs 3+N cycles after req_valid is accepted, or 2+N on an address-cache hit.
- Boundary conditions:
  - rsp_stb outside WAIT_RSP is ignored, including a late response after a timeout.
  - A terminal rsp_stb in the same cycle the counter expires: the response wins.
  - cmd_busy held high indefinitely: the block stalls in SEND_ADDR/SEND_DATA; no timeout applies there.
  - req_valid outside IDLE is ignored; the requester must hold req_valid until it sees req_ready.
  - Reset mid-transaction: aborts immediately with no resp_valid, and the next request sends the address command.
  - Back-to-back requests: the next request is accepted the cycle after DONE.

Test Plan:
- Reset release, then write addr 0x0000_0000 data 0xAABBCCDD; master returns rsp {00,0} 2 cycles later → cmd words {10,0,1,30'h0} then {01,AABBCCDD}, resp_valid=1, resp_err=0, total 5 cycles.
- Read addr 0x30 with rsp {01,32'h12345678} → cmd {10,0,1,30'hC} then {00,0}, resp_rdata=0x12345678.
- Repeat the read at 0x30 with ADDR_CACHE=1 → only {00,0} is emitted, one cycle shorter; with ADDR_CACHE=0 the address word is re-sent.
- cmd_busy held high 4 cycles during SEND_ADDR → cmd_word stable, cmd_stb high throughout, exactly one address transfer.
- No response after a read → resp_err=1 and resp_rdata=0 exactly TIMEOUT_CYCLES cycles after the read word transfers; the next request to the same address re-sends the address word; a late rsp is ignored.
- rsp {10,...} echo followed by {11,0} on a write → echo ignored, resp_err=1; reset asserted mid-WAIT_RSP → no resp_valid, all outputs at reset values.
